// File: rtl/intr_gateway.sv
// intr_gateway: collects Width interrupt lines into pending / in-service
// state and presents a single registered irq plus a claim/complete
// handshake to software.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   src_i          interrupt lines from peripheral stages
//   le_i           per-source trigger mode (1 = rising edge, 0 = level)
//   enable_i       per-source enable for selection and irq
//   claim_re_i     claim strobe; takes the source shown on claim_id_o
//   claim_id_o     lowest eligible source ID (source k -> k+1), 0 = none
//   complete_we_i  complete strobe
//   complete_id_i  ID being completed; re-arms that source if in service
//   pending_o      pending vector
//   irq_o          registered request to the core

// Per-source next-state cell. Purely combinational; flops live in the top.
module intr_gateway_src (
  input  logic src_i,
  input  logic src_q_i,
  input  logic le_i,
  input  logic pending_q_i,
  input  logic ia_q_i,
  input  logic claim_hit_i,
  input  logic comp_hit_i,
  output logic pending_d_o,
  output logic ia_d_o
);
  logic set_evt;

  // Edge mode sets regardless of in-service so the event is remembered
  // across completion; level mode only sets on an idle source.
  assign set_evt = le_i ? (src_i & ~src_q_i)
                        : (src_i & ~pending_q_i & ~ia_q_i);

  // A fresh event beats the claim clearing pending.
  assign pending_d_o = set_evt | (pending_q_i & ~claim_hit_i);
  assign ia_d_o      = claim_hit_i | (ia_q_i & ~comp_hit_i);
endmodule

module intr_gateway #(
  parameter int Width   = 32,
  parameter int IdWidth = $clog2(Width + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [Width-1:0]   src_i,
  input  logic [Width-1:0]   le_i,
  input  logic [Width-1:0]   enable_i,
  input  logic               claim_re_i,
  output logic [IdWidth-1:0] claim_id_o,
  input  logic               complete_we_i,
  input  logic [IdWidth-1:0] complete_id_i,
  output logic [Width-1:0]   pending_o,
  output logic               irq_o
);
  logic [Width-1:0]   src_q, pending_q, pending_d, ia_q, ia_d;
  logic [Width-1:0]   eligible, claim_hit, comp_hit;
  logic [IdWidth-1:0] claim_id;
  logic               irq_q;

  assign eligible = pending_q & enable_i & ~ia_q;

  // Priority pick: scan from the top so the lowest index wins.
  always_comb begin
    claim_id = '0;
    for (int k = Width - 1; k >= 0; k--)
      if (eligible[k]) claim_id = IdWidth'(k + 1);
  end

  genvar k;
  generate
    for (k = 0; k < Width; k++) begin : g_src
      // IDs outside 1..Width never match any source, so they fall out here.
      assign claim_hit[k] = claim_re_i & (claim_id == IdWidth'(k + 1));
      assign comp_hit[k]  = complete_we_i & ia_q[k] &
                            (complete_id_i == IdWidth'(k + 1));

      intr_gateway_src u_src (
        .src_i       (src_i[k]),
        .src_q_i     (src_q[k]),
        .le_i        (le_i[k]),
        .pending_q_i (pending_q[k]),
        .ia_q_i      (ia_q[k]),
        .claim_hit_i (claim_hit[k]),
        .comp_hit_i  (comp_hit[k]),
        .pending_d_o (pending_d[k]),
        .ia_d_o      (ia_d[k])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      pending_q <= '0;
      ia_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      src_q     <= src_i;
      pending_q <= pending_d;
      ia_q      <= ia_d;
      irq_q     <= |eligible;
    end
  end

  assign claim_id_o = claim_id;
  assign pending_o  = pending_q;
  assign irq_o      = irq_q;
endmodule
